// File: rtl/decodificador_multiplexado_pkg.sv
// Shared display constants for the multiplexed 7-segment timer display.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package decodificador_multiplexado_pkg;

    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Element n holds the pattern for digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    typedef enum logic [IDX_W-1:0] {
        DIG_SEG_UNI = 2'd0,
        DIG_SEG_DEZ = 2'd1,
        DIG_MIN_UNI = 2'd2,
        DIG_MIN_DEZ = 2'd3
    } dig_sel_e;

    function automatic logic bcd_invalid(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/decodificador_multiplexado_if.sv
// Display bus: enable/load strobes and BCD digits in, segments/anodes/error out.
interface decodificador_multiplexado_if;

    logic       enablen;
    logic       load;
    logic [3:0] bcd_min_dez;
    logic [3:0] bcd_min_uni;
    logic [3:0] bcd_seg_dez;
    logic [3:0] bcd_seg_uni;
    logic [6:0] seg;
    logic [3:0] an;
    logic       erro;

    modport master (
        output enablen, load, bcd_min_dez, bcd_min_uni, bcd_seg_dez, bcd_seg_uni,
        input  seg, an, erro
    );

    modport slave (
        input  enablen, load, bcd_min_dez, bcd_min_uni, bcd_seg_dez, bcd_seg_uni,
        output seg, an, erro
    );

endinterface

// File: rtl/decodificador_multiplexado_bcd_7seg.sv
// Combinational BCD to active-low 7-segment decode; codes above 9 show a dash.
module bcd_7seg
    import decodificador_multiplexado_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (!bcd_invalid(bcd_i)) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
    end

endmodule

// File: rtl/decodificador_multiplexado.sv
// Four-digit multiplexed display driver: latches MM:SS BCD digits and scans
// them onto shared segment lines, one digit every SCAN_DIV clocks.
module decodificador_multiplexado
    import decodificador_multiplexado_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input logic                         clk,
    input logic                         reset,
    decodificador_multiplexado_if.slave disp
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dig_sel_e         idx_q, idx_d;
    logic [3:0]       min_dez_q, min_dez_d;
    logic [3:0]       min_uni_q, min_uni_d;
    logic [3:0]       seg_dez_q, seg_dez_d;
    logic [3:0]       seg_uni_q, seg_uni_d;
    logic             erro_q, erro_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             wrap;
    logic [3:0]       sel_bcd;
    logic [6:0]       dec_seg;

    always_comb begin
        wrap  = (cnt_q == CNT_LAST);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? dig_sel_e'(idx_q + 1'b1) : idx_q;

        min_dez_d = min_dez_q;
        min_uni_d = min_uni_q;
        seg_dez_d = seg_dez_q;
        seg_uni_d = seg_uni_q;
        if (disp.load) begin
            min_dez_d = disp.bcd_min_dez;
            min_uni_d = disp.bcd_min_uni;
            seg_dez_d = disp.bcd_seg_dez;
            seg_uni_d = disp.bcd_seg_uni;
        end

        erro_d = bcd_invalid(min_dez_q) | bcd_invalid(min_uni_q) |
                 bcd_invalid(seg_dez_q) | bcd_invalid(seg_uni_q);

        case (idx_q)
            DIG_SEG_UNI: sel_bcd = seg_uni_q;
            DIG_SEG_DEZ: sel_bcd = seg_dez_q;
            DIG_MIN_UNI: sel_bcd = min_uni_q;
            default:     sel_bcd = min_dez_q;
        endcase
    end

    bcd_7seg u_bcd_7seg (
        .bcd_i (sel_bcd),
        .seg_o (dec_seg)
    );

    // Leading zero of the minutes is blanked, but its anode still fires so timing stays uniform.
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = (idx_q == DIG_MIN_DEZ && min_dez_q == 4'd0) ? SEG_BLANK : dec_seg;
        if (disp.enablen) begin
            an_d  = 4'b1111;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= DIG_SEG_UNI;
            min_dez_q <= 4'd0;
            min_uni_q <= 4'd0;
            seg_dez_q <= 4'd0;
            seg_uni_q <= 4'd0;
            erro_q    <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            min_dez_q <= min_dez_d;
            min_uni_q <= min_uni_d;
            seg_dez_q <= seg_dez_d;
            seg_uni_q <= seg_uni_d;
            erro_q    <= erro_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign disp.seg  = seg_q;
    assign disp.an   = an_q;
    assign disp.erro = erro_q;

endmodule

// File: tb/tb_decodificador_multiplexado.sv
// Directed bench for decodificador_multiplexado with SCAN_DIV=4; edges are
// numbered from the first reset edge (E0) and expectations are tied to them.
module tb_decodificador_multiplexado;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = -1;

    decodificador_multiplexado_if dif ();

    decodificador_multiplexado #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got=%b exp=%b", tag, edge_n, got, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        check_val({tag, "_an"}, {4'b0, dif.an}, {4'b0, an_e});
        check_val({tag, "_seg"}, {1'b0, dif.seg}, {1'b0, seg_e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int k);
        while (edge_n < k) tick();
    endtask

    task automatic set_digits(input logic [3:0] md, input logic [3:0] mu,
                              input logic [3:0] sd, input logic [3:0] su);
        dif.bcd_min_dez = md;
        dif.bcd_min_uni = mu;
        dif.bcd_seg_dez = sd;
        dif.bcd_seg_uni = su;
    endtask

    logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_tab [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    initial begin
        dif.enablen = 1'b0;
        dif.load    = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);

        // E0: reset edge
        tick();
        check_disp("reset", 4'b1111, 7'b1111111);
        check_val("reset_erro", {7'b0, dif.erro}, 8'd0);

        // E1: first edge out of reset, loading 1,2,3,4
        reset = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        check_disp("first_after_reset", 4'b1110, 7'b1000000);

        // E2..E17: full scan, each digit held for 4 edges
        for (int k = 2; k <= 17; k++) begin
            tick();
            check_disp("scan1234", an_tab[((k - 1) / 4) % 4], seg_tab[((k - 1) / 4) % 4]);
        end
        check_val("scan_erro", {7'b0, dif.erro}, 8'd0);

        // Leading-zero blanking: min_dez=0, min_uni=5, loaded at E18
        set_digits(4'd0, 4'd5, 4'd0, 4'd0);
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        run_to(25); check_disp("min_uni5_a", 4'b1011, 7'b0010010);
        run_to(28); check_disp("min_uni5_b", 4'b1011, 7'b0010010);
        run_to(29); check_disp("lz_blank_a", 4'b0111, 7'b1111111);
        run_to(32); check_disp("lz_blank_b", 4'b0111, 7'b1111111);

        // Invalid seg_uni=12 loaded at E33
        set_digits(4'd0, 4'd5, 4'd0, 4'b1100);
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        tick();
        check_disp("dash", 4'b1110, 7'b0111111);
        check_val("erro_set", {7'b0, dif.erro}, 8'd1);
        run_to(36); check_val("erro_hold", {7'b0, dif.erro}, 8'd1);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        run_to(39);
        check_val("erro_clear", {7'b0, dif.erro}, 8'd0);
        check_disp("zeros_segdez", 4'b1101, 7'b1000000);

        // enablen high across E42..E51 (scan in min_uni slot at E41)
        run_to(41);
        dif.enablen = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_disp("disabled", 4'b1111, 7'b1111111);
        end
        dif.enablen = 1'b0;
        tick(); check_disp("resume_a", 4'b1110, 7'b1000000);
        tick(); check_disp("resume_b", 4'b1101, 7'b1000000);

        // Reset in the an=1011 slot, with a concurrent load of invalid digits
        set_digits(4'd7, 4'd8, 4'd9, 4'd6);
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        run_to(57);
        check_disp("pre_reset", 4'b1011, 7'b0000000);
        reset = 1'b1;
        set_digits(4'd15, 4'd15, 4'd15, 4'd15);
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        reset    = 1'b0;
        check_disp("mid_reset", 4'b1111, 7'b1111111);
        check_val("mid_reset_erro", {7'b0, dif.erro}, 8'd0);
        tick(); check_disp("post_reset", 4'b1110, 7'b1000000);
        run_to(60); check_val("post_reset_erro", {7'b0, dif.erro}, 8'd0);
        run_to(63); check_disp("cleared_segdez", 4'b1101, 7'b1000000);
        run_to(67); check_disp("cleared_minuni", 4'b1011, 7'b1000000);
        run_to(71); check_disp("cleared_mindez", 4'b0111, 7'b1111111);

        // Load exactly on the idx3->idx0 wrap at E74
        run_to(73);
        set_digits(4'd5, 4'd6, 4'd7, 4'd3);
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        check_disp("wrap_edge", 4'b0111, 7'b1111111);
        tick(); check_disp("wrap_new", 4'b1110, 7'b0110000);
        run_to(79); check_disp("wrap_segdez", 4'b1101, 7'b1111000);
        run_to(80); check_val("wrap_erro", {7'b0, dif.erro}, 8'd0);
        run_to(87); check_disp("mindez5", 4'b0111, 7'b0010010);

        // load held for E88..E90 with changing seg_uni; last value (9) wins
        set_digits(4'd5, 4'd6, 4'd7, 4'd1);
        dif.load = 1'b1;
        tick();
        dif.bcd_seg_uni = 4'd2;
        tick();
        dif.bcd_seg_uni = 4'd9;
        tick();
        dif.load = 1'b0;
        run_to(92); check_disp("held_load", 4'b1110, 7'b0010000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decodificador_multiplexado.md
DECODIFICADOR_MULTIPLEXADO -- requirements
Module: decodificador_multiplexado

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each digit stays selected; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enablen  input  1  active-low display enable; 1 blanks all digits.
REQ-005 load  input  1  one-cycle strobe; captures the four BCD inputs.
REQ-006 bcd_min_dez  input  4  minutes tens digit (BCD).
REQ-007 bcd_min_uni  input  4  minutes units digit (BCD).
REQ-008 bcd_seg_dez  input  4  seconds tens digit (BCD).
REQ-009 bcd_seg_uni  input  4  seconds units digit (BCD).
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 an  output  4  digit anodes, active-low one-cold, registered; an[0]=seg_uni, an[3]=min_dez.
REQ-012 erro  output  1  registered; 1 while any latched digit is greater than 9.

Function
REQ-013 On load=1, all four inputs SHALL be latched at that edge; unlatched inputs have no effect on outputs.
REQ-014 Divider counter SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index (0..3) SHALL advance on wrap, 3 wrapping to 0.
REQ-015 Each cycle, seg/an SHALL be registered from the current index and latched digit: one cycle latency from index change to output change.
REQ-016 Decode table (seg): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 Latched digit 10..15 SHALL display dash 0111111, and erro SHALL be 1 from the cycle after the load edge until a load with all digits 0..9.
REQ-018 Leading-zero blanking: when the index selects min_dez and latched min_dez is 0, seg SHALL be 1111111 while an still selects that digit.
REQ-019 enablen=1: an=1111 and seg=1111111 from the next edge; counter, index, latch, and erro keep operating.
REQ-020 load concurrent with enablen=1 SHALL still latch; load concurrent with index wrap SHALL show new data in the same registered update as the new index.
REQ-021 load held high for several cycles SHALL re-latch on every high edge; the last edge wins.

Reset
REQ-022 reset=1 SHALL clear the counter, index, and all four latched digits to 0, and erro to 0; an=1111 and seg=1111111 on the reset edge.
REQ-023 reset SHALL take priority over load and enablen; reset during any point of the scan SHALL restart the scan at index 0, counter 0.
REQ-024 On the first edge after reset deasserts (enablen=0), an SHALL be 1110 and seg 1000000.

Structure
REQ-025 The segment constants (digit patterns, DASH, BLANK) and the index width SHALL live in a shared package, which the timer path also uses.
REQ-026 Combinational BCD-to-7-segment decode SHALL be one sub-module, bcd_7seg (4-bit in, 7-bit out, dash for >9), instantiated once after the index mux.

Verification
REQ-027 Reset, then load 1,2,3,4 (min_dez..seg_uni) with enablen=0 and SCAN_DIV=4 -> an cycles 1110,1101,1011,0111 every 4 clocks, with seg 0011001,0110000,0100100,1111001 respectively.
REQ-028 Load min_dez=0, min_uni=5 -> while an=0111, seg=1111111; while an=1011, seg=0010010.
REQ-029 Load seg_uni=4'b1100 -> erro=1 on the next cycle, and the an=1110 slot shows 0111111; a subsequent load of all zeros -> erro=0.
REQ-030 Raise enablen for 10 cycles mid-scan -> an=1111 and seg=1111111 throughout; after it drops, the index continues from where the free-running scan reached.
REQ-031 Assert reset for 1 cycle while an=1011 -> an=1111 and seg=1111111 at that edge, then an=1110 and seg=1000000, and the latched digits read 0.
REQ-032 Pulse load exactly on an index wrap edge with new values -> the first slot after the wrap shows the new digit, with no stale-digit cycle.
